// File: rtl/bsg_gateway_reset_seq_pkg.sv
// Shared types and helpers for the gateway reset sequencer.
//   - bsg_gateway_reset_seq_state_e : sequencer FSM states
//   - bsg_gateway_reset_seq_cnt_width : width of the shared cycle counter,
//     sized for the larger of the stable window and the stage delay
package bsg_gateway_reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STABLE  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } bsg_gateway_reset_seq_state_e;

    localparam int lock_stable_cycles_default_lp = 1024;
    localparam int stage_delay_cycles_default_lp = 256;
    localparam int num_stages_default_lp         = 4;
    localparam int loss_count_width_default_lp   = 8;

    // Counter width: $clog2 of max(lock_stable_cycles, stage_delay_cycles).
    function automatic int bsg_gateway_reset_seq_cnt_width(input int stable_cycles,
                                                           input int stage_cycles);
        int max_cycles;
        if (stable_cycles > stage_cycles) begin
            max_cycles = stable_cycles;
        end else begin
            max_cycles = stage_cycles;
        end
        return $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/bsg_gateway_lock_sync.sv
// Two-flop synchroniser for a single asynchronous lock indication.
// Ports:
//   clk_i   : destination-domain clock
//   reset_i : asynchronous active-high reset, clears both flops to 0
//   async_i : asynchronous level input
//   sync_o  : synchronised level, two clk_i edges after sampling
module bsg_gateway_lock_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_r;

    // Two-stage capture; first stage may go metastable, second resolves it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_r <= 1'b0;
            sync_o <= 1'b0;
        end else begin
            meta_r <= async_i;
            sync_o <= meta_r;
        end
    end

endmodule

// File: rtl/bsg_gateway_reset_seq.sv
// Gateway reset sequencer. Synchronises the PLL and DCM lock indications,
// waits for them to be stable, then releases a staged set of resets one
// stage at a time. Any lock loss or software request re-asserts all resets;
// lock losses are recorded in a sticky flag and a saturating counter.
// Ports:
//   clk_i        : destination-domain clock
//   reset_i      : asynchronous active-high reset
//   pll_locked_i : PLL lock (asynchronous)
//   dcm_locked_i : DCM lock (asynchronous)
//   sw_reset_i   : single-cycle request to re-run the sequence
//   clear_i      : clears lock_lost_o and loss_count_o
//   reset_o      : active-high stage resets, bit 0 releases first
//   ready_o      : all stages released
//   lock_lost_o  : sticky lock-loss flag
//   loss_count_o : saturating lock-loss event count
module bsg_gateway_reset_seq
    import bsg_gateway_reset_seq_pkg::*;
#(
    parameter int lock_stable_cycles_p = lock_stable_cycles_default_lp,
    parameter int stage_delay_cycles_p = stage_delay_cycles_default_lp,
    parameter int num_stages_p         = num_stages_default_lp,
    parameter int loss_count_width_p   = loss_count_width_default_lp
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          pll_locked_i,
    input  logic                          dcm_locked_i,
    input  logic                          sw_reset_i,
    input  logic                          clear_i,
    output logic [num_stages_p-1:0]       reset_o,
    output logic                          ready_o,
    output logic                          lock_lost_o,
    output logic [loss_count_width_p-1:0] loss_count_o
);

    localparam int cnt_w_lp = bsg_gateway_reset_seq_cnt_width(lock_stable_cycles_p,
                                                              stage_delay_cycles_p);
    // Index must be able to hold num_stages_p, meaning "all stages released".
    localparam int idx_w_lp = $clog2(num_stages_p + 1);

    localparam logic [cnt_w_lp-1:0]           stable_last_lp = cnt_w_lp'(lock_stable_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0]           stage_last_lp  = cnt_w_lp'(stage_delay_cycles_p - 1);
    localparam logic [idx_w_lp-1:0]           idx_done_lp    = idx_w_lp'(num_stages_p);
    localparam logic [num_stages_p-1:0]       all_ones_lp    = {num_stages_p{1'b1}};
    localparam logic [num_stages_p-1:0]       stage_one_lp   = num_stages_p'(1);
    localparam logic [loss_count_width_p-1:0] count_max_lp   = {loss_count_width_p{1'b1}};

    logic pll_sync_s;
    logic dcm_sync_s;
    logic locked_s;

    bsg_gateway_lock_sync u_pll_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (pll_locked_i),
        .sync_o  (pll_sync_s)
    );

    bsg_gateway_lock_sync u_dcm_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (dcm_locked_i),
        .sync_o  (dcm_sync_s)
    );

    assign locked_s = pll_sync_s & dcm_sync_s;

    bsg_gateway_reset_seq_state_e state_r, state_s;
    logic [cnt_w_lp-1:0]           cnt_r, cnt_s;
    logic [idx_w_lp-1:0]           idx_r, idx_s;
    logic [num_stages_p-1:0]       rst_r, rst_s;
    logic                          ready_r, ready_s;
    logic                          lost_r, lost_s;
    logic [loss_count_width_p-1:0] count_r, count_s;
    logic                          loss_s;
    logic                          restart_s;
    logic                          lost_base_s;
    logic [loss_count_width_p-1:0] count_base_s;

    // Loss is only meaningful once out of HOLD; loss beats a software request.
    assign loss_s    = (state_r != HOLD) && !locked_s;
    assign restart_s = (state_r != HOLD) && locked_s && sw_reset_i;

    // Next-state and next-output logic of the sequencer FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rst_s   = rst_r;
        ready_s = ready_r;
        if (loss_s) begin
            state_s = HOLD;
            cnt_s   = {cnt_w_lp{1'b0}};
            idx_s   = {idx_w_lp{1'b0}};
            rst_s   = all_ones_lp;
            ready_s = 1'b0;
        end else if (restart_s) begin
            state_s = STABLE;
            cnt_s   = {cnt_w_lp{1'b0}};
            idx_s   = {idx_w_lp{1'b0}};
            rst_s   = all_ones_lp;
            ready_s = 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    cnt_s   = {cnt_w_lp{1'b0}};
                    idx_s   = {idx_w_lp{1'b0}};
                    rst_s   = all_ones_lp;
                    ready_s = 1'b0;
                    if (locked_s) begin
                        state_s = STABLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                STABLE: begin
                    if (cnt_r == stable_last_lp) begin
                        state_s = RELEASE;
                        cnt_s   = {cnt_w_lp{1'b0}};
                        idx_s   = idx_w_lp'(1);
                        rst_s   = all_ones_lp & ~stage_one_lp;
                    end else begin
                        cnt_s   = cnt_r + cnt_w_lp'(1);
                    end
                end
                RELEASE: begin
                    // Index reaching num_stages_p means the last stage has
                    // already been released; ready follows one cycle later.
                    if (idx_r == idx_done_lp) begin
                        state_s = RUN;
                        ready_s = 1'b1;
                    end else if (cnt_r == stage_last_lp) begin
                        cnt_s   = {cnt_w_lp{1'b0}};
                        idx_s   = idx_r + idx_w_lp'(1);
                        rst_s   = rst_r & ~(stage_one_lp << idx_r);
                    end else begin
                        cnt_s   = cnt_r + cnt_w_lp'(1);
                    end
                end
                RUN: begin
                    ready_s = 1'b1;
                end
                default: begin
                    state_s = HOLD;
                    cnt_s   = {cnt_w_lp{1'b0}};
                    idx_s   = {idx_w_lp{1'b0}};
                    rst_s   = all_ones_lp;
                    ready_s = 1'b0;
                end
            endcase
        end
    end

    // Lock-loss recording: clear first, then a coincident loss is applied on top.
    always_comb begin
        if (clear_i) begin
            lost_base_s  = 1'b0;
            count_base_s = {loss_count_width_p{1'b0}};
        end else begin
            lost_base_s  = lost_r;
            count_base_s = count_r;
        end
        if (loss_s) begin
            lost_s = 1'b1;
            if (count_base_s == count_max_lp) begin
                count_s = count_base_s;
            end else begin
                count_s = count_base_s + loss_count_width_p'(1);
            end
        end else begin
            lost_s  = lost_base_s;
            count_s = count_base_s;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= HOLD;
            cnt_r   <= {cnt_w_lp{1'b0}};
            idx_r   <= {idx_w_lp{1'b0}};
            rst_r   <= all_ones_lp;
            ready_r <= 1'b0;
            lost_r  <= 1'b0;
            count_r <= {loss_count_width_p{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            rst_r   <= rst_s;
            ready_r <= ready_s;
            lost_r  <= lost_s;
            count_r <= count_s;
        end
    end

    assign reset_o      = rst_r;
    assign ready_o      = ready_r;
    assign lock_lost_o  = lost_r;
    assign loss_count_o = count_r;

endmodule
